branch_cond_unit: RTL and testbench

- Consumer end of the ALU flag interface.
- Latches Z/V/N into a status register and owns the program counter.
- Evaluates conditional-branch requests from the controller FSM against the latched flags, then commits either PC+1 or the branch target.
- Sits between the datapath (ALU flags) and the instruction-fetch address path.

---
 rtl/branch_cond_unit.sv | 147 ++++++++++++++
 tb/tb_branch_cond_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// Branch condition unit: latches ALU flags, owns the PC, and resolves conditional branches.
// Latency: accept edge -> done high two cycles later; updated pc visible the cycle after done.
// Backpressure: br_ready is high only in IDLE, so at most one branch is in flight (one per 3 cycles).
//
// Ports:
//   clk, reset                  - clock and synchronous active-high reset
//   Z_in, V_in, N_in, loads     - ALU flags and status-register load strobe
//   pc_inc                      - sequential fetch request (honoured only in IDLE without a branch accept)
//   br_valid / br_ready         - branch request handshake; cond and sximm8 are sampled on accept
//   pc, status                  - current program counter and latched flags {N,V,Z}
//   done, taken                 - one-cycle commit pulse and its taken/not-taken result
//   taken_count                 - saturating taken-branch counter (only when BRANCH_STATS_EN is defined, else 0)
//
// Optional feature macro: BRANCH_STATS_EN

module branch_cond_unit #(
   parameter int              PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Z_in,
   input  logic            V_in,
   input  logic            N_in,
   input  logic            loads,
   input  logic            pc_inc,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [2:0]      cond,
   input  logic [15:0]     sximm8,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      status,
   output logic            done,
   output logic            taken,
   output logic [15:0]     taken_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EVAL   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]      r_state;
   logic [PC_W-1:0] r_pc;
   logic [2:0]      r_status;
   logic [2:0]      r_cond;
   logic [2:0]      r_flags;
   logic [PC_W-1:0] r_tgt;
   logic [PC_W-1:0] r_seq;
   logic            r_take;
   logic            r_done;

   logic            w_accept;
   logic [PC_W-1:0] w_seq;
   logic [PC_W-1:0] w_tgt;
   logic            w_take;
   logic            w_unused_imm;

   assign br_ready = (r_state == S_IDLE);
   assign w_accept = br_valid & br_ready;

   // Both addresses wrap naturally at PC_W bits; offset bits above PC_W are dropped.
   assign w_seq        = r_pc + PC_W'(1);
   assign w_tgt        = w_seq + sximm8[PC_W-1:0];
   assign w_unused_imm = ^sximm8;

   // r_flags = {N,V,Z}
   always_comb begin
      w_take = 1'b0;
      case (r_cond)
         3'b000:  w_take = 1'b1;
         3'b001:  w_take = r_flags[0];
         3'b010:  w_take = ~r_flags[0];
         3'b011:  w_take = r_flags[2] ^ r_flags[1];
         3'b100:  w_take = (r_flags[2] ^ r_flags[1]) | r_flags[0];
         default: w_take = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_status <= 3'b000;
         r_cond   <= 3'b000;
         r_flags  <= 3'b000;
         r_tgt    <= '0;
         r_seq    <= '0;
         r_take   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         if (loads) begin
            r_status <= {N_in, V_in, Z_in};
         end
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  // Snapshot the pre-edge status so a same-cycle load cannot steer this branch.
                  r_cond  <= cond;
                  r_flags <= r_status;
                  r_tgt   <= w_tgt;
                  r_seq   <= w_seq;
                  r_state <= S_EVAL;
               end else if (pc_inc) begin
                  r_pc <= w_seq;
               end
            end
            S_EVAL: begin
               // done/taken are registered here so they are valid throughout COMMIT.
               r_take  <= w_take;
               r_done  <= 1'b1;
               r_state <= S_COMMIT;
            end
            S_COMMIT: begin
               r_pc    <= r_take ? r_tgt : r_seq;
               r_take  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign pc     = r_pc;
   assign status = r_status;
   assign done   = r_done;
   assign taken  = r_take;

`ifdef BRANCH_STATS_EN
   logic [15:0] r_taken_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_taken_count <= 16'h0000;
      end else if ((r_state == S_COMMIT) && r_take && (r_taken_count != 16'hFFFF)) begin
         r_taken_count <= r_taken_count + 16'd1;
      end
   end

   assign taken_count = r_taken_count;
`else
   assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;

   logic        clk;
   logic        reset;
   logic        Z_in, V_in, N_in;
   logic        loads;
   logic        pc_inc;
   logic        br_valid;
   logic        br_ready;
   logic [2:0]  cond;
   logic [15:0] sximm8;
   logic [8:0]  pc;
   logic [2:0]  status;
   logic        done;
   logic        taken;
   logic [15:0] taken_count;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int         m_pc;
   logic [2:0] m_status;
   int         m_count;

   typedef struct {
      int         pre_inc;
      logic       pre_ld;
      logic [2:0] pre_flags;  // {N,V,Z}
      logic [2:0] c;
      logic [15:0] imm;
      logic       pcinc;
      logic       ld;
      logic [2:0] ldv;
      logic       exp_tk;     // hand-derived expectations for directed cases
      int         exp_pc;
   } br_t;

   typedef struct {
      logic       acc_rdy;
      logic       eval_rdy;
      logic [8:0] pc_eval;
      int         lat;
      logic       tk;
      logic [8:0] pc_after;
      logic       rdy_after;
      logic [2:0] status_after;
      logic [15:0] count_after;
   } obs_t;

   branch_cond_unit #(.PC_W(9), .RESET_PC(9'd0)) dut (
      .clk(clk), .reset(reset), .Z_in(Z_in), .V_in(V_in), .N_in(N_in),
      .loads(loads), .pc_inc(pc_inc), .br_valid(br_valid), .br_ready(br_ready),
      .cond(cond), .sximm8(sximm8), .pc(pc), .status(status), .done(done),
      .taken(taken), .taken_count(taken_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic take_rule(input logic [2:0] c, input logic [2:0] f);
      logic n, v, z;
      n = f[2]; v = f[1]; z = f[0];
      case (c)
         3'd0:    return 1'b1;
         3'd1:    return z;
         3'd2:    return !z;
         3'd3:    return n != v;
         3'd4:    return (n != v) || z;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_pc = 0; m_status = 3'b000; m_count = 0;
   endtask

   task automatic model_pre(input br_t b);
      m_pc = (m_pc + b.pre_inc) % 512;
      if (b.pre_ld) m_status = b.pre_flags;
   endtask

   task automatic model_branch(input br_t b, output logic tk, output int npc);
      tk  = take_rule(b.c, m_status);
      npc = tk ? (m_pc + 1 + (int'(b.imm) % 512)) % 512 : (m_pc + 1) % 512;
      m_pc = npc;
      if (b.ld) m_status = b.ldv;
`ifdef BRANCH_STATS_EN
      if (tk && m_count < 65535) m_count++;
`endif
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; br_valid = 1'b0; pc_inc = 1'b0; loads = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic apply_pre(input br_t b);
      for (int i = 0; i < b.pre_inc; i++) begin
         @(negedge clk); pc_inc = 1'b1;
         @(posedge clk);
      end
      if (b.pre_ld) begin
         @(negedge clk);
         pc_inc = 1'b0; loads = 1'b1;
         {N_in, V_in, Z_in} = b.pre_flags;
         @(posedge clk);
      end
      @(negedge clk);
      pc_inc = 1'b0; loads = 1'b0;
   endtask

   task automatic run_branch(input br_t b, output obs_t o);
      @(negedge clk);
      br_valid = 1'b1; cond = b.c; sximm8 = b.imm;
      pc_inc = b.pcinc; loads = b.ld; {N_in, V_in, Z_in} = b.ldv;
      o.acc_rdy = br_ready;
      @(posedge clk);
      @(negedge clk);
      br_valid = 1'b0; pc_inc = 1'b0; loads = 1'b0;
      o.eval_rdy = br_ready;
      o.pc_eval  = pc;
      o.lat = 0; o.tk = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (done) begin
            o.lat = i; o.tk = taken;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      o.pc_after     = pc;
      o.rdy_after    = br_ready;
      o.status_after = status;
      o.count_after  = taken_count;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      n_checks++; if (pc !== 9'd0) $display("FAIL reset_pc: got %0d expected 0", pc); else n_pass++;
      n_checks++; if (status !== 3'b000) $display("FAIL reset_status: got %b expected 000", status); else n_pass++;
      n_checks++; if (br_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", br_ready); else n_pass++;
      n_checks++; if (done !== 1'b0 || taken !== 1'b0) $display("FAIL reset_done_taken: got %b%b expected 00", done, taken); else n_pass++;
      n_checks++; if (taken_count !== 16'h0) $display("FAIL reset_count: got %0d expected 0", taken_count); else n_pass++;
   endtask

   task automatic test_pc_inc();
      @(negedge clk); pc_inc = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         n_checks++; if (pc !== 9'(i)) $display("FAIL pc_inc_step%0d: got %0d expected %0d", i, pc, i); else n_pass++;
      end
      pc_inc = 1'b0;
      do_reset();
      n_checks++; if (pc !== 9'd0 || status !== 3'b000 || br_ready !== 1'b1)
         $display("FAIL pc_inc_rereset: got pc=%0d status=%b rdy=%b expected 0/000/1", pc, status, br_ready);
      else n_pass++;
      @(negedge clk); pc_inc = 1'b1;
      repeat (3) @(negedge clk);
      pc_inc = 1'b0;
      m_pc = 3;
   endtask

   task automatic test_directed();
      br_t  tab[9];
      obs_t o;
      logic mtk;
      int   mpc;
      //           inc ld  flags  c     imm      pinc ld  ldv   tk  pc
      tab[0] = '{0, 1, 3'b001, 3'd1, 16'h0005, 0, 0, 3'b000, 1, 9};
      tab[1] = '{0, 1, 3'b000, 3'd1, 16'h0005, 0, 0, 3'b000, 0, 10};
      tab[2] = '{0, 0, 3'b000, 3'd2, 16'h0005, 0, 0, 3'b000, 1, 16};
      tab[3] = '{4, 1, 3'b100, 3'd3, 16'hFFFE, 0, 0, 3'b000, 1, 19};
      tab[4] = '{1, 0, 3'b000, 3'd5, 16'hFFFE, 0, 0, 3'b000, 0, 21};
      tab[5] = '{0, 0, 3'b000, 3'd0, 16'd489,  0, 0, 3'b000, 1, 511};
      tab[6] = '{0, 0, 3'b000, 3'd0, 16'h0001, 0, 0, 3'b000, 1, 1};
      tab[7] = '{0, 0, 3'b000, 3'd0, 16'h0000, 1, 0, 3'b000, 1, 2};
      tab[8] = '{0, 1, 3'b001, 3'd1, 16'h0003, 0, 1, 3'b000, 1, 6};
      foreach (tab[k]) begin
         int pre_pc;
         apply_pre(tab[k]);
         model_pre(tab[k]);
         pre_pc = m_pc;
         run_branch(tab[k], o);
         model_branch(tab[k], mtk, mpc);
         n_checks++; if (o.lat !== 2) $display("FAIL dir%0d_latency: got %0d expected 2", k, o.lat); else n_pass++;
         n_checks++; if (o.tk !== tab[k].exp_tk || mtk !== tab[k].exp_tk)
            $display("FAIL dir%0d_taken: got %b (model %b) expected %b", k, o.tk, mtk, tab[k].exp_tk);
         else n_pass++;
         n_checks++; if (o.pc_after !== 9'(tab[k].exp_pc) || mpc != tab[k].exp_pc)
            $display("FAIL dir%0d_pc: got %0d (model %0d) expected %0d", k, o.pc_after, mpc, tab[k].exp_pc);
         else n_pass++;
         n_checks++; if (o.pc_eval !== 9'(pre_pc) || o.eval_rdy !== 1'b0)
            $display("FAIL dir%0d_eval: got pc=%0d rdy=%b expected pc=%0d rdy=0", k, o.pc_eval, o.eval_rdy, pre_pc);
         else n_pass++;
         n_checks++; if (o.status_after !== m_status)
            $display("FAIL dir%0d_status: got %b expected %b", k, o.status_after, m_status);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      br_t  b;
      obs_t o;
      logic mtk;
      int   mpc;
      for (int k = 0; k < 30; k++) begin
         b.pre_inc   = $urandom_range(0, 3);
         b.pre_ld    = 1'($urandom);
         b.pre_flags = 3'($urandom);
         b.c         = 3'($urandom);
         b.imm       = 16'($urandom);
         b.pcinc     = 1'($urandom);
         b.ld        = 1'($urandom);
         b.ldv       = 3'($urandom);
         b.exp_tk    = 1'b0;
         b.exp_pc    = 0;
         apply_pre(b);
         model_pre(b);
         run_branch(b, o);
         model_branch(b, mtk, mpc);
         n_checks++; if (o.acc_rdy !== 1'b1 || o.lat !== 2 || o.rdy_after !== 1'b1)
            $display("FAIL rnd%0d_handshake: got rdy=%b lat=%0d rdy_after=%b expected 1/2/1", k, o.acc_rdy, o.lat, o.rdy_after);
         else n_pass++;
         n_checks++; if (o.tk !== mtk)
            $display("FAIL rnd%0d_taken: got %b expected %b (cond %0d)", k, o.tk, mtk, b.c);
         else n_pass++;
         n_checks++; if (o.pc_after !== 9'(mpc))
            $display("FAIL rnd%0d_pc: got %0d expected %0d", k, o.pc_after, mpc);
         else n_pass++;
         n_checks++; if (o.status_after !== m_status || o.count_after !== 16'(m_count))
            $display("FAIL rnd%0d_status_count: got %b/%0d expected %b/%0d", k, o.status_after, o.count_after, m_status, m_count);
         else n_pass++;
      end
   endtask

   task automatic test_reset_in_eval();
      int saw_done;
      @(negedge clk);
      br_valid = 1'b1; cond = 3'd0; sximm8 = 16'h0007;
      @(posedge clk);
      @(negedge clk);
      br_valid = 1'b0;
      n_checks++; if (br_ready !== 1'b0) $display("FAIL rie_in_eval: got rdy=%b expected 0", br_ready); else n_pass++;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      saw_done = 0;
      n_checks++; if (pc !== 9'd0 || br_ready !== 1'b1 || taken_count !== 16'h0)
         $display("FAIL rie_state: got pc=%0d rdy=%b cnt=%0d expected 0/1/0", pc, br_ready, taken_count);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         if (done) saw_done++;
         @(negedge clk);
      end
      n_checks++; if (saw_done != 0 || pc !== 9'd0)
         $display("FAIL rie_no_done: got %0d done pulses pc=%0d expected 0 pulses pc=0", saw_done, pc);
      else n_pass++;
   endtask

   task automatic test_count();
      br_t  b;
      obs_t o;
      logic mtk;
      int   mpc;
      int   exp_cnt;
      do_reset();
      b = '{0, 0, 3'b000, 3'd0, 16'h0002, 0, 0, 3'b000, 1, 0};
      for (int k = 0; k < 4; k++) begin
         b.c = (k == 2) ? 3'd7 : 3'd0;
         run_branch(b, o);
         model_branch(b, mtk, mpc);
      end
`ifdef BRANCH_STATS_EN
      exp_cnt = 3;
`else
      exp_cnt = 0;
`endif
      n_checks++; if (taken_count !== 16'(exp_cnt))
         $display("FAIL count_total: got %0d expected %0d", taken_count, exp_cnt);
      else n_pass++;
      n_checks++; if (pc !== 9'(mpc))
         $display("FAIL count_pc: got %0d expected %0d", pc, mpc);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1; Z_in = 1'b0; V_in = 1'b0; N_in = 1'b0; loads = 1'b0;
      pc_inc = 1'b0; br_valid = 1'b0; cond = 3'd0; sximm8 = 16'h0;
      model_reset();
      test_reset();
      test_pc_inc();
      test_directed();
      test_random();
      test_reset_in_eval();
      test_count();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
